score_collector: RTL and testbench

Serial-to-parallel front end for the 10-way argmax stage. It accepts a stream of 8-bit class scores, one per beat, over a valid/ready handshake and assembles each 10-beat frame into parallel registers x0..x9. It presents a complete frame to the argmax comparator tree with a valid/ready handshake. It detects malformed frames, discards them, and resynchronises.

---
 rtl/score_collector.sv | 133 +++++++++++++
 tb/tb_score_collector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/score_collector.sv
// Collects a 10-beat stream of class scores into parallel registers x0..x9
// and hands each well-formed frame to the argmax stage over valid/ready.
module score_collector #(
    parameter int DATA_W = 8,
    parameter int N      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] x4,
    output logic [DATA_W-1:0] x5,
    output logic [DATA_W-1:0] x6,
    output logic [DATA_W-1:0] x7,
    output logic [DATA_W-1:0] x8,
    output logic [DATA_W-1:0] x9,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        SKIP = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    state_t            state;
    state_t            state_n;
    logic [3:0]        idx;
    logic [3:0]        idx_n;
    logic              err_n;
    logic              wr;
    logic              cnt_inc;
    logic              accept;
    logic [DATA_W-1:0] xr [N];

    assign s_ready = (state != HOLD);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        err_n   = 1'b0;
        wr      = 1'b0;
        cnt_inc = 1'b0;
        unique case (state)
            FILL: begin
                if (accept) begin
                    wr = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_n = 4'd0;
                        if (s_last) begin
                            state_n = HOLD;
                        end else begin
                            // Overlong frame: flag once, then drop the tail.
                            err_n   = 1'b1;
                            state_n = SKIP;
                        end
                    end else if (s_last) begin
                        err_n = 1'b1;
                        idx_n = 4'd0;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = FILL;
                    cnt_inc = 1'b1;
                end
            end
            SKIP: begin
                if (accept && s_last) begin
                    state_n = FILL;
                    idx_n   = 4'd0;
                end
            end
            default: begin
                state_n = FILL;
                idx_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= 4'd0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            err       <= err_n;
            out_valid <= (state_n == HOLD);
            if (cnt_inc) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) xr[k] <= '0;
        end else if (wr) begin
            for (int k = 0; k < N; k++) begin
                if (idx == 4'(k)) xr[k] <= s_data;
            end
        end
    end

    assign x0 = xr[0];
    assign x1 = xr[1];
    assign x2 = xr[2];
    assign x3 = xr[3];
    assign x4 = xr[4];
    assign x5 = xr[5];
    assign x6 = xr[6];
    assign x7 = xr[7];
    assign x8 = xr[8];
    assign x9 = xr[9];

endmodule

// File: tb/tb_score_collector.sv
// Directed bench for score_collector: normal, backpressure, short, long,
// mid-frame reset and frame counter wrap.
module tb_score_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic [7:0] frame_cnt;

    logic [7:0] xv [10];
    int         vectors = 0;
    int         errs = 0;
    int         err_seen = 0;
    int         ov_seen = 0;

    score_collector #(.DATA_W(8), .N(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .x5(x5), .x6(x6), .x7(x7), .x8(x8), .x9(x9),
        .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    assign xv[0] = x0;
    assign xv[1] = x1;
    assign xv[2] = x2;
    assign xv[3] = x3;
    assign xv[4] = x4;
    assign xv[5] = x5;
    assign xv[6] = x6;
    assign xv[7] = x7;
    assign xv[8] = x8;
    assign xv[9] = x9;

    // Reads the pre-edge value, so each high cycle counts once.
    always @(posedge clk) begin
        if (err) err_seen++;
        if (out_valid) ov_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] step);
        for (int k = 0; k < 10; k++) begin
            beat(b0 + 8'(k) * step, k == 9);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        s_last    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        for (int k = 0; k < 10; k++) chk("rst_x", 32'(xv[k]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd1);

        // Normal frame
        out_ready = 1'b1;
        err_seen  = 0;
        ov_seen   = 0;
        send_frame(8'h10, 8'h10);
        chk("norm_out_valid", 32'(out_valid), 32'd1);
        chk("norm_s_ready_hold", 32'(s_ready), 32'd0);
        for (int k = 0; k < 10; k++)
            chk("norm_x", 32'(xv[k]), 32'((k + 1) * 16));
        @(negedge clk);
        chk("norm_out_valid_fall", 32'(out_valid), 32'd0);
        chk("norm_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("norm_ov_cycles", 32'(ov_seen), 32'd1);
        chk("norm_err_seen", 32'(err_seen), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        send_frame(8'h30, 8'h01);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            s_valid = 1'b1;
            s_data  = 8'hFF;
            @(negedge clk);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_x0", 32'(x0), 32'h30);
            chk("bp_x9", 32'(x9), 32'h39);
        end
        s_valid   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out_valid_fall", 32'(out_valid), 32'd0);
        chk("bp_s_ready_back", 32'(s_ready), 32'd1);
        chk("bp_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("bp_x5", 32'(x5), 32'h35);

        // Short frame
        err_seen = 0;
        beat(8'hE1, 1'b0);
        beat(8'hE2, 1'b0);
        beat(8'hE3, 1'b0);
        beat(8'hE4, 1'b1);
        chk("short_err", 32'(err), 32'd1);
        chk("short_out_valid", 32'(out_valid), 32'd0);
        send_frame(8'h01, 8'h01);
        chk("short_next_valid", 32'(out_valid), 32'd1);
        chk("short_next_x0", 32'(x0), 32'h01);
        chk("short_next_x3", 32'(x3), 32'h04);
        chk("short_next_x9", 32'(x9), 32'h0A);
        chk("short_err_seen", 32'(err_seen), 32'd1);
        @(negedge clk);
        chk("short_frame_cnt", 32'(frame_cnt), 32'd3);

        // Long frame
        err_seen = 0;
        for (int k = 0; k < 13; k++) begin
            beat(8'hB0 + 8'(k), k == 12);
            if (k == 9) chk("long_err_at10", 32'(err), 32'd1);
        end
        chk("long_out_valid", 32'(out_valid), 32'd0);
        chk("long_err_seen", 32'(err_seen), 32'd1);
        chk("long_s_ready", 32'(s_ready), 32'd1);
        chk("long_x0_kept", 32'(x0), 32'hB0);
        send_frame(8'h50, 8'h01);
        chk("long_next_valid", 32'(out_valid), 32'd1);
        chk("long_next_x0", 32'(x0), 32'h50);
        chk("long_next_x9", 32'(x9), 32'h59);
        @(negedge clk);
        chk("long_frame_cnt", 32'(frame_cnt), 32'd4);

        // Reset during beat 6
        for (int k = 0; k < 5; k++) beat(8'h60 + 8'(k), 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h65;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_x0", 32'(x0), 32'd0);
        chk("mrst_x4", 32'(x4), 32'd0);
        chk("mrst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h70, 8'h01);
        chk("mrst_next_valid", 32'(out_valid), 32'd1);
        chk("mrst_next_x0", 32'(x0), 32'h70);
        chk("mrst_next_x5", 32'(x5), 32'h75);
        @(negedge clk);
        chk("mrst_next_cnt", 32'(frame_cnt), 32'd1);

        // Wrap: 256 good frames since reset
        for (int f = 0; f < 254; f++) begin
            send_frame(8'(f), 8'h01);
            @(negedge clk);
        end
        chk("wrap_cnt_255", 32'(frame_cnt), 32'd255);
        send_frame(8'hC0, 8'h02);
        chk("wrap_last_x9", 32'(x9), 32'hD2);
        @(negedge clk);
        chk("wrap_cnt_0", 32'(frame_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
